// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the raw lines, deframes 11-bit frames
// and queues good scan-code bytes in a small FIFO with a ready/nextdata_n pop port.
module ps2_rx_fifo #(
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [15:0] TIMEOUT    = 16'd50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  c_s1, c_s2, c_hist, d_s1, d_s2;
  logic [9:0]            sr;
  logic [3:0]            count;
  logic [15:0]           idle;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2:0]   wptr, rptr;

  logic        fall, last, frame_ok, push, pop, empty, full, push_ok;
  logic [10:0] frame;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_s1   <= 1'b1;
      c_s2   <= 1'b1;
      c_hist <= 1'b1;
      d_s1   <= 1'b1;
      d_s2   <= 1'b1;
    end else begin
      c_s1   <= ps2_clk;
      c_s2   <= c_s1;
      c_hist <= c_s2;
      d_s1   <= ps2_data;
      d_s2   <= d_s1;
    end
  end

  // frame[0] is the start bit, frame[10] the stop bit once the 11th sample arrives
  always_comb begin
    fall     = c_hist & ~c_s2;
    frame    = {d_s2, sr};
    last     = fall && (count == 4'd10);
    frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);
    push     = last & frame_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      count     <= '0;
      idle      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall) begin
        idle <= '0;
        sr   <= frame[10:1];
        if (count == 4'd0 && d_s2) begin
          count <= '0;
        end else if (last) begin
          count     <= '0;
          frame_err <= ~frame_ok;
        end else begin
          count <= count + 4'd1;
        end
      end else if (count != 4'd0) begin
        // a stalled device mid-frame must not wedge the deframer
        if (idle == TIMEOUT - 16'd1) begin
          count     <= '0;
          idle      <= '0;
          frame_err <= 1'b1;
        end else begin
          idle <= idle + 16'd1;
        end
      end else begin
        idle <= '0;
      end
    end
  end

  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]) &&
              (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]);
    pop     = ~empty & ~nextdata_n;
    push_ok = push & (~full | pop);
    ready   = ~empty;
    data    = empty ? 8'h00 : mem[rptr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wptr[DEPTH_LOG2-1:0]] <= frame[8:1];
  end

  // overflow is sticky until the consumer next makes room
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (pop)                        overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged onto the PS/2 lines,
// expected bytes go into a queue and are compared as the consumer pops them.
module tb_ps2_rx_fifo;

  localparam int          DEPTH_LOG2 = 3;
  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [15:0] TIMEOUT    = 16'd200;
  localparam int          HALF       = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data, nextdata_n;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  int tests  = 0;
  int failed = 0;
  int err_cnt = 0;
  logic [7:0] exp_q [$];
  logic       exp_ovf = 1'b0;

  ps2_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) err_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one PS/2 bit: data set up in the high phase, sampled by the device falling edge
  task automatic send_bit(input logic b, input bit chk_lat);
    @(negedge clk);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    if (chk_lat) begin
      repeat (2) @(posedge clk);
      #1 check("latency_before", {15'd0, ready}, 16'd0);
      @(posedge clk);
      #1 check("latency_after", {15'd0, ready}, 16'd1);
    end
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit chk_lat);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], chk_lat && (i == 10));
    if (!bad_par) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end
    wait_cycles(HALF);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, {15'd0, ready}, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_ready"}, {15'd0, ready}, 16'd1);
      check({tag, "_data"}, {8'd0, data}, {8'd0, e});
      exp_ovf = 1'b0;
    end
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  initial begin
    int e0;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {15'd0, ready}, 16'd0);
    check("rst_overflow", {15'd0, overflow}, 16'd0);
    check("rst_frame_err", {15'd0, frame_err}, 16'd0);
    check("rst_data", {8'd0, data}, 16'h0000);

    // single frame with exact push latency, then drain
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t1_no_err", err_cnt - e0, 16'd0);
    pop_check("t1_pop");
    pop_check("t1_after");

    // ordering across two queued bytes
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_check("t2_pop0");
    pop_check("t2_pop1");
    pop_check("t2_after");

    // bad parity is rejected with a single-cycle pulse
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("t3_err_pulse", err_cnt - e0, 16'd1);
    check("t3_ready", {15'd0, ready}, 16'd0);
    send_frame(8'h32, 1'b0, 1'b0);
    pop_check("t3_good");

    // a lone high sample at count 0 is ignored without error
    e0 = err_cnt;
    send_bit(1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("t4_no_err", err_cnt - e0, 16'd0);
    pop_check("t4_pop");

    // overflow on the 9th frame, cleared by the first pop
    for (int i = 1; i <= DEPTH + 1; i++) begin
      send_frame(i[7:0], 1'b0, 1'b0);
      if (i == DEPTH) check("t5_full_no_ovf", {15'd0, overflow}, 16'd0);
    end
    check("t5_ovf_set", {15'd0, overflow}, {15'd0, exp_ovf});
    pop_check("t5_pop1");
    check("t5_ovf_clr", {15'd0, overflow}, {15'd0, exp_ovf});
    for (int i = 2; i <= DEPTH; i++) pop_check("t5_pop");
    pop_check("t5_after");

    // stalled clock mid-frame times out, next frame is clean
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 1'b0);
    wait_cycles(int'(TIMEOUT) + 20);
    check("t6_timeout_err", err_cnt - e0, 16'd1);
    send_frame(8'h45, 1'b0, 1'b0);
    check("t6_no_extra_err", err_cnt - e0, 16'd1);
    pop_check("t6_pop");

    // reset mid-frame with bytes queued
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    check("t7_ready", {15'd0, ready}, 16'd0);
    check("t7_ovf", {15'd0, overflow}, 16'd0);
    e0 = err_cnt;
    send_frame(8'h16, 1'b0, 1'b0);
    check("t7_no_err", err_cnt - e0, 16'd0);
    pop_check("t7_pop");
    pop_check("t7_after");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
